output_port_fifo: RTL

//  Parametrised successor to the single 8-bit output register: CHANNELS independent output

---
 rtl/output_port_fifo_pkg.sv | 13 +
 rtl/outport_chan_fifo.sv | 83 ++++++++
 rtl/output_port_fifo.sv | 50 +++++
 3 files changed

// File: rtl/output_port_fifo_pkg.sv
// Shared defaults and helpers for the multi-channel output port FIFO.
package output_port_fifo_pkg;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefChannels = 2;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/outport_chan_fifo.sv
// One output channel: FIFO storage, pointers, count, last-popped value and sticky overflow.
// Overflow flag is built only when OUTPORT_OVF_FLAG_EN is defined.
module outport_chan_fifo #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [DataW-1:0] head_o,
  output logic [DataW-1:0] current_o,
  output logic             ovf_o,
  input  logic             ovf_clr_i
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DataW-1:0] current_q;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(Depth));
  assign empty   = (count_q == '0);
  // Both qualifiers use pre-edge state: a full channel drops a push even if it pops this edge.
  assign do_push = push_i & ~full;
  assign do_pop  = ready_i & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      current_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        current_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign valid_o   = ~empty;
  assign full_o    = full;
  assign empty_o   = empty;
  assign head_o    = mem_q[rd_ptr_q];
  assign current_o = current_q;

`ifdef OUTPORT_OVF_FLAG_EN
  logic ovf_q;

  // Set beats clear when both happen on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (push_i && full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr_i;
  assign ovf_o          = 1'b0;
`endif

endmodule

// File: rtl/output_port_fifo.sv
// CHANNELS independent output ports, each a DEPTH-entry FIFO written from the bus.
// Optional sticky overflow flags are enabled by defining OUTPORT_OVF_FLAG_EN.
module output_port_fifo
  import output_port_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned CHANNELS = DefChannels,
  parameter int unsigned CH_W     = sel_width(CHANNELS)
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [DATA_W-1:0]          BUS_IN,
  input  logic                       WE,
  input  logic [CH_W-1:0]            CH_SEL,
  output logic [CHANNELS-1:0]        FULL,
  output logic [CHANNELS-1:0]        EMPTY,
  output logic [CHANNELS-1:0]        DISP_VALID,
  input  logic [CHANNELS-1:0]        DISP_READY,
  output logic [CHANNELS*DATA_W-1:0] DISP_DATA,
  output logic [CHANNELS*DATA_W-1:0] CURRENT,
  output logic [CHANNELS-1:0]        OVF,
  input  logic                       OVF_CLR
);

  // Out-of-range selects match no channel, so such writes vanish without side effects.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic push;
    assign push = WE && (CH_SEL == CH_W'(i));

    outport_chan_fifo #(
      .DataW(DATA_W),
      .Depth(DEPTH)
    ) u_chan (
      .clk_i    (CLK),
      .rst_ni   (RESET),
      .push_i   (push),
      .data_i   (BUS_IN),
      .ready_i  (DISP_READY[i]),
      .valid_o  (DISP_VALID[i]),
      .full_o   (FULL[i]),
      .empty_o  (EMPTY[i]),
      .head_o   (DISP_DATA[i*DATA_W +: DATA_W]),
      .current_o(CURRENT[i*DATA_W +: DATA_W]),
      .ovf_o    (OVF[i]),
      .ovf_clr_i(OVF_CLR)
    );
  end

endmodule
